// File: rtl/rac_pkg.sv
// rtl/rac_pkg.sv - shared types and constants for the register access controller
package rac_pkg;

    localparam int REG_IDX_W = 5;
    localparam int WB_ADDR_W = 32;
    localparam logic [31:0] RESET_DATA = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        RD1_REQ,
        RD1_WAIT,
        RD2_REQ,
        RD2_WAIT,
        WR_REQ,
        WR_WAIT,
        OP_OUT
    } state_t;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_REQ,
        BUS_WAIT
    } bus_phase_t;

    function automatic logic [WB_ADDR_W-1:0] idx_to_addr(input logic [REG_IDX_W-1:0] idx);
        return {{(WB_ADDR_W-REG_IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/reg_access_ctrl_if.sv
// rtl/reg_access_ctrl_if.sv - Wishbone link between the controller and the register file
interface reg_access_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              stb;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              stall;

    modport master (
        output stb, we, addr, wdata,
        input  rdata, ack, stall
    );

    modport slave (
        input  stb, we, addr, wdata,
        output rdata, ack, stall
    );
endinterface

// File: rtl/wb_single_master.sv
// rtl/wb_single_master.sv - one-outstanding Wishbone request/wait engine with ack timeout
module wb_single_master
    import rac_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_idx,
    input  logic [DATA_W-1:0]    i_wdata,
    output logic                 o_accepted,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [DATA_W-1:0]    o_rdata,
    reg_access_ctrl_if.master    wb
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    bus_phase_t        phase;
    logic [CNT_W-1:0]  wait_cnt;
    logic              stb_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign wb.stb   = stb_q;
    assign wb.we    = we_q;
    assign wb.addr  = addr_q;
    assign wb.wdata = wdata_q;

    // Ack wins over a timeout landing on the same cycle; acks outside WAIT are ignored.
    assign o_accepted = (phase == BUS_REQ) && !wb.stall;
    assign o_timeout  = (phase == BUS_WAIT) && !wb.ack && (wait_cnt == CNT_LAST);
    assign o_done     = (phase == BUS_WAIT) && (wb.ack || (wait_cnt == CNT_LAST));
    assign o_rdata    = wb.ack ? wb.rdata : DATA_W'(RESET_DATA);

    // Strobe/address held through stall; a new start may overlap the completing cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            phase    <= BUS_IDLE;
            wait_cnt <= '0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (i_start) begin
            phase    <= BUS_REQ;
            wait_cnt <= '0;
            stb_q    <= 1'b1;
            we_q     <= i_we;
            addr_q   <= idx_to_addr(i_idx);
            wdata_q  <= i_wdata;
        end else begin
            case (phase)
                BUS_REQ: begin
                    if (!wb.stall) begin
                        stb_q    <= 1'b0;
                        phase    <= BUS_WAIT;
                        wait_cnt <= '0;
                    end
                end
                BUS_WAIT: begin
                    if (o_done) begin
                        phase <= BUS_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: phase <= BUS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - operand-read / writeback sequencer over a single Wishbone master
module reg_access_ctrl
    import rac_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_rd_valid,
    output logic                 o_rd_ready,
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    output logic                 o_op_valid,
    input  logic                 i_op_ready,
    output logic [DATA_W-1:0]    o_rs1_data,
    output logic [DATA_W-1:0]    o_rs2_data,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [REG_IDX_W-1:0] i_wr_rd,
    input  logic [DATA_W-1:0]    i_wr_data,
    output logic                 o_wr_done,
    reg_access_ctrl_if.master    wb,
    output logic                 o_err
);
    state_t                 state;
    logic [REG_IDX_W-1:0]   rs1_q;
    logic [REG_IDX_W-1:0]   rs2_q;
    logic [DATA_W-1:0]      rs1_data_q;
    logic [DATA_W-1:0]      rs2_data_q;
    logic                   wr_done_q;
    logic                   err_q;

    logic                   bus_start;
    logic                   bus_we;
    logic [REG_IDX_W-1:0]   bus_idx;
    logic [DATA_W-1:0]      bus_wdata;
    logic                   bus_accepted;
    logic                   bus_done;
    logic                   bus_timeout;
    logic [DATA_W-1:0]      bus_rdata;

    assign o_wr_ready = (state == IDLE);
    assign o_rd_ready = (state == IDLE) && !i_wr_valid;
    assign o_op_valid = (state == OP_OUT);
    assign o_rs1_data = rs1_data_q;
    assign o_rs2_data = rs2_data_q;
    assign o_wr_done  = wr_done_q;
    assign o_err      = err_q;

    // Launch a bus request on the same edge the FSM enters a *_REQ state.
    always_comb begin
        bus_start = 1'b0;
        bus_we    = 1'b0;
        bus_idx   = '0;
        bus_wdata = '0;
        case (state)
            IDLE: begin
                if (i_wr_valid) begin
                    if (i_wr_rd != '0) begin
                        bus_start = 1'b1;
                        bus_we    = 1'b1;
                        bus_idx   = i_wr_rd;
                        bus_wdata = i_wr_data;
                    end
                end else if (i_rd_valid) begin
                    if (i_rs1 != '0) begin
                        bus_start = 1'b1;
                        bus_idx   = i_rs1;
                    end else if (i_rs2 != '0) begin
                        bus_start = 1'b1;
                        bus_idx   = i_rs2;
                    end
                end
            end
            RD1_WAIT: begin
                if (bus_done && (rs2_q != '0) && (rs2_q != rs1_q)) begin
                    bus_start = 1'b1;
                    bus_idx   = rs2_q;
                end
            end
            default: ;
        endcase
    end

    // Main sequencer: write beats read on a tie, x0 and rs2==rs1 skip the bus.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= DATA_W'(RESET_DATA);
            rs2_data_q <= DATA_W'(RESET_DATA);
            wr_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_wr_valid) begin
                        if (i_wr_rd == '0) wr_done_q <= 1'b1;
                        else               state     <= WR_REQ;
                    end else if (i_rd_valid) begin
                        rs1_q <= i_rs1;
                        rs2_q <= i_rs2;
                        if (i_rs1 != '0) begin
                            state <= RD1_REQ;
                        end else begin
                            rs1_data_q <= '0;
                            if (i_rs2 == '0) begin
                                rs2_data_q <= '0;
                                state      <= OP_OUT;
                            end else begin
                                state <= RD2_REQ;
                            end
                        end
                    end
                end
                RD1_REQ: if (bus_accepted) state <= RD1_WAIT;
                RD1_WAIT: begin
                    if (bus_done) begin
                        rs1_data_q <= bus_rdata;
                        err_q      <= bus_timeout;
                        if (rs2_q == '0) begin
                            rs2_data_q <= '0;
                            state      <= OP_OUT;
                        end else if (rs2_q == rs1_q) begin
                            rs2_data_q <= bus_rdata;
                            state      <= OP_OUT;
                        end else begin
                            state <= RD2_REQ;
                        end
                    end
                end
                RD2_REQ: if (bus_accepted) state <= RD2_WAIT;
                RD2_WAIT: begin
                    if (bus_done) begin
                        rs2_data_q <= bus_rdata;
                        err_q      <= bus_timeout;
                        state      <= OP_OUT;
                    end
                end
                WR_REQ: if (bus_accepted) state <= WR_WAIT;
                WR_WAIT: begin
                    if (bus_done) begin
                        wr_done_q <= 1'b1;
                        err_q     <= bus_timeout;
                        state     <= IDLE;
                    end
                end
                OP_OUT: if (i_op_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    wb_single_master #(
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_wb_master (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_start    (bus_start),
        .i_we       (bus_we),
        .i_idx      (bus_idx),
        .i_wdata    (bus_wdata),
        .o_accepted (bus_accepted),
        .o_done     (bus_done),
        .o_timeout  (bus_timeout),
        .o_rdata    (bus_rdata),
        .wb         (wb)
    );

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - self-checking bench for reg_access_ctrl
module tb_reg_access_ctrl;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd_valid, rd_ready, op_valid, op_ready;
    logic [4:0]  rs1, rs2, wr_rd;
    logic [31:0] rs1_data, rs2_data, wr_data;
    logic        wr_valid, wr_ready, wr_done, err;

    always #5 clk = ~clk;

    reg_access_ctrl_if #(.DATA_W(32)) wb ();

    reg_access_ctrl #(.DATA_W(32), .ACK_TIMEOUT(TO)) dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_rd_valid (rd_valid),
        .o_rd_ready (rd_ready),
        .i_rs1      (rs1),
        .i_rs2      (rs2),
        .o_op_valid (op_valid),
        .i_op_ready (op_ready),
        .o_rs1_data (rs1_data),
        .o_rs2_data (rs2_data),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .i_wr_rd    (wr_rd),
        .i_wr_data  (wr_data),
        .o_wr_done  (wr_done),
        .wb         (wb),
        .o_err      (err)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Slave register file and the bench's own reference copy of it.
    logic [31:0] slave_regs [32];
    logic [31:0] model_regs [32];

    int          cyc = 0;
    int          ack_at = -1;
    int          ack_delay = 2;
    bit          no_ack = 1'b0;
    logic [4:0]  tx_addr = '0;
    int          n_tx = 0, n_stb = 0, first_we = -1, last_we = -1, last_addr = -1;
    int          overlap_viol = 0;
    int          stall_budget = 0, n_stalled = 0, stall_viol = 0;
    bit          rand_stall = 1'b0;
    logic        held_stb = 1'b0;
    logic [31:0] held_addr = '0;
    int          n_err = 0, n_wr_done = 0, n_opv = 0;

    // Slave: record accepted transactions at the clock edge.
    always @(posedge clk) begin
        cyc++;
        if (reset_n) begin
            if (wb.stb) n_stb++;
            if (wb.stb && !wb.stall) begin
                if (ack_at >= cyc) overlap_viol++;
                n_tx++;
                if (first_we < 0) first_we = int'(wb.we);
                last_we   = int'(wb.we);
                last_addr = int'(wb.addr);
                tx_addr   = wb.addr[4:0];
                if (wb.we) slave_regs[wb.addr[4:0]] = wb.wdata;
                ack_at = no_ack ? -1 : cyc + ack_delay;
            end
        end
    end

    // Slave: drive ack/data/stall on the falling edge, watch strobe stability under stall.
    always @(negedge clk) begin
        wb.ack   = (ack_at == cyc + 1);
        wb.rdata = wb.ack ? slave_regs[tx_addr] : $urandom;
        if (wb.stall && held_stb) begin
            if (!(wb.stb === 1'b1 && wb.addr === held_addr)) stall_viol++;
        end
        held_stb  = wb.stb;
        held_addr = wb.addr;
        if (wb.stb && stall_budget > 0) begin
            wb.stall = 1'b1;
            stall_budget--;
            n_stalled++;
        end else if (rand_stall && wb.stb) begin
            wb.stall = ($urandom_range(0, 2) == 0);
        end else begin
            wb.stall = 1'b0;
        end
        n_err     += int'(err);
        n_wr_done += int'(wr_done);
        n_opv     += int'(op_valid);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_val(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : model_regs[idx];
    endfunction

    function automatic int exp_tx(input logic [4:0] a, input logic [4:0] b);
        return ((a != 0) ? 1 : 0) + ((b != 0 && b != a) ? 1 : 0);
    endfunction

    task automatic do_write(input logic [4:0] rd, input logic [31:0] data, output int lat);
        int t;
        @(negedge clk);
        check1("wr_ready", wr_ready, 1'b1);
        wr_valid = 1'b1; wr_rd = rd; wr_data = data;
        @(negedge clk);
        wr_valid = 1'b0;
        t = 0;
        while (!wr_done && t < 100) begin @(negedge clk); t++; end
        check1("wr_done_seen", wr_done, 1'b1);
        if (rd != 0) model_regs[rd] = data;
        lat = t;
        @(negedge clk);
        check1("wr_done_pulse", wr_done, 1'b0);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b, input int hold,
                           output logic [31:0] r1, output logic [31:0] r2,
                           output int lat, output logic e);
        int t;
        @(negedge clk);
        check1("rd_ready", rd_ready, 1'b1);
        rd_valid = 1'b1; rs1 = a; rs2 = b;
        @(negedge clk);
        rd_valid = 1'b0;
        t = 0;
        while (!op_valid && t < 100) begin @(negedge clk); t++; end
        check1("op_valid_seen", op_valid, 1'b1);
        r1 = rs1_data; r2 = rs2_data; e = err; lat = t;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check1("op_hold_valid", op_valid, 1'b1);
            check("op_hold_rs1", rs1_data, r1);
            check("op_hold_rs2", rs2_data, r2);
        end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        check1("op_release", op_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r1, r2, d;
        logic        e;
        int          lat, t, c0, c1, c2, c3;
        logic [4:0]  a, b;

        reset_n = 1'b0; rd_valid = 1'b0; op_ready = 1'b0; wr_valid = 1'b0;
        rs1 = '0; rs2 = '0; wr_rd = '0; wr_data = '0;
        wb.ack = 1'b0; wb.stall = 1'b0; wb.rdata = '0;
        for (int i = 0; i < 32; i++) begin
            slave_regs[i] = 32'hA500_0000 + i;
            model_regs[i] = 32'hA500_0000 + i;
        end
        slave_regs[7] = 32'h1234_5678;
        model_regs[7] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        check1("rst_stb", wb.stb, 1'b0);
        check1("rst_we", wb.we, 1'b0);
        check("rst_addr", wb.addr, 32'd0);
        check("rst_wdata", wb.wdata, 32'd0);
        check1("rst_op_valid", op_valid, 1'b0);
        check1("rst_wr_done", wr_done, 1'b0);
        check1("rst_err", err, 1'b0);
        check("rst_rs1_data", rs1_data, 32'hFFFF_FFFF);
        check("rst_rs2_data", rs2_data, 32'hFFFF_FFFF);
        reset_n = 1'b1;

        // 1: write rd=5
        n_stb = 0; n_tx = 0;
        do_write(5'd5, 32'hDEAD_BEEF, lat);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_stb_cycles", 32'(n_stb), 32'd1);
        check("t1_tx", 32'(n_tx), 32'd1);
        check("t1_we", 32'(last_we), 32'd1);
        check("t1_addr", 32'(last_addr), 32'd5);
        check("t1_file", slave_regs[5], 32'hDEAD_BEEF);

        // 2: read rs1=5, rs2=7 with 3 held cycles
        n_tx = 0;
        do_read(5'd5, 5'd7, 3, r1, r2, lat, e);
        check("t2_rs1", r1, 32'hDEAD_BEEF);
        check("t2_rs2", r2, 32'h1234_5678);
        check("t2_latency", 32'(lat), 32'd6);
        check("t2_tx", 32'(n_tx), 32'd2);
        check("t2_we", 32'(last_we), 32'd0);

        // 3: x0 read and x0 write stay off the bus
        n_stb = 0;
        do_read(5'd0, 5'd0, 0, r1, r2, lat, e);
        check("t3_rs1", r1, 32'd0);
        check("t3_rs2", r2, 32'd0);
        check1("t3_fast", lat <= 1, 1'b1);
        do_write(5'd0, 32'h5555_AAAA, lat);
        check("t3_wr_latency", 32'(lat), 32'd0);
        check("t3_stb_cycles", 32'(n_stb), 32'd0);

        // 4: rs1==rs2 with 4 stall cycles
        n_tx = 0; n_stalled = 0; stall_viol = 0; stall_budget = 4;
        do_read(5'd9, 5'd9, 0, r1, r2, lat, e);
        check("t4_rs1", r1, exp_val(5'd9));
        check("t4_rs2", r2, exp_val(5'd9));
        check("t4_tx", 32'(n_tx), 32'd1);
        check("t4_stalled", 32'(n_stalled), 32'd4);
        check("t4_stall_viol", 32'(stall_viol), 32'd0);
        check("t4_latency", 32'(lat), 32'd7);

        // 5: simultaneous write and read; write goes first
        n_tx = 0; first_we = -1; d = $urandom;
        @(negedge clk);
        wr_valid = 1'b1; wr_rd = 5'd11; wr_data = d;
        rd_valid = 1'b1; rs1 = 5'd11; rs2 = 5'd0;
        #1;
        check1("t5_rd_ready_low", rd_ready, 1'b0);
        check1("t5_wr_ready", wr_ready, 1'b1);
        @(negedge clk);
        wr_valid = 1'b0;
        t = 0;
        while (!wr_done && t < 100) begin @(negedge clk); t++; end
        check1("t5_wr_done", wr_done, 1'b1);
        model_regs[11] = d;
        check1("t5_rd_ready_after", rd_ready, 1'b1);
        @(negedge clk);
        rd_valid = 1'b0;
        t = 0;
        while (!op_valid && t < 100) begin @(negedge clk); t++; end
        check1("t5_op_valid", op_valid, 1'b1);
        check("t5_rs1", rs1_data, exp_val(5'd11));
        check("t5_first_we", 32'(first_we), 32'd1);
        check("t5_tx", 32'(n_tx), 32'd2);
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;

        // 6a: ack timeout
        no_ack = 1'b1; c0 = n_err;
        do_read(5'd3, 5'd0, 0, r1, r2, lat, e);
        check("t6_rs1", r1, 32'hFFFF_FFFF);
        check("t6_rs2", r2, 32'd0);
        check1("t6_err", e, 1'b1);
        check("t6_latency", 32'(lat), 32'(TO + 1));
        check("t6_err_count", 32'(n_err - c0), 32'd1);
        no_ack = 1'b0;

        // 6b: reset while waiting for ack, then a late ack
        ack_delay = 6;
        @(negedge clk);
        rd_valid = 1'b1; rs1 = 5'd4; rs2 = 5'd6;
        @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check1("t6_rst_stb", wb.stb, 1'b0);
        check1("t6_rst_op_valid", op_valid, 1'b0);
        check("t6_rst_rs1", rs1_data, 32'hFFFF_FFFF);
        reset_n = 1'b1;
        #1;
        check1("t6_rst_idle", rd_ready, 1'b1);
        c0 = n_err; c1 = n_wr_done; c2 = n_opv; c3 = n_stb;
        repeat (10) @(negedge clk);
        check("t6_late_err", 32'(n_err - c0), 32'd0);
        check("t6_late_wr_done", 32'(n_wr_done - c1), 32'd0);
        check("t6_late_op_valid", 32'(n_opv - c2), 32'd0);
        check("t6_late_stb", 32'(n_stb - c3), 32'd0);

        // Random traffic against the reference register model
        rand_stall = 1'b1;
        for (int it = 0; it < 40; it++) begin
            ack_delay = $urandom_range(1, 4);
            n_tx = 0;
            a = 5'($urandom_range(0, 7));
            b = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_write(a, d, lat);
                check("rnd_wr_tx", 32'(n_tx), (a != 0) ? 32'd1 : 32'd0);
                check("rnd_wr_file", slave_regs[a], (a != 0) ? d : slave_regs[0]);
            end else begin
                do_read(a, b, $urandom_range(0, 2), r1, r2, lat, e);
                check("rnd_rs1", r1, exp_val(a));
                check("rnd_rs2", r2, exp_val(b));
                check("rnd_tx", 32'(n_tx), 32'(exp_tx(a, b)));
                check1("rnd_err", e, 1'b0);
            end
        end
        rand_stall = 1'b0;
        check("overlap", 32'(overlap_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
